// File: rtl/nand_sweep_pkg.sv
// Shared definitions for the 3-input NAND sweep self-check: state
// encoding, default hold time and the golden NAND reference.
package nand_sweep_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] APPLY = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_APPLY = APPLY,
        ST_CHECK = CHECK,
        ST_DONE  = DONE
    } state_t;

    // Settle cycles per vector before it is checked (must be >= 1).
    localparam int HOLD_CYC_DEF = 4;

    // Golden NAND over the low n_in bits of vec: 0 only when all are 1.
    function automatic logic golden_nand(input logic [31:0] vec, input int n_in);
        logic [31:0] m;
        m = (n_in >= 32) ? '1 : ((32'd1 << n_in) - 32'd1);
        return ((vec & m) != m);
    endfunction

endpackage

// File: rtl/sweep_hold_timer.sv
// Loadable down-counter that times how long each vector settles.
// o_zero is decoded from the register, so there is no input-to-output path.
module sweep_hold_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // Load has priority; otherwise count down while enabled, parking at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            // NOTE: sequential state uses non-blocking assignment so every
            // flop samples pre-edge values regardless of block ordering.
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/nand_sweep_ctrl.sv
// Exhaustive self-check sequencer for three NAND implementations:
// drives a shared vector, waits HOLD_CYC cycles, compares all three
// outputs against the golden NAND and accumulates the results.
module nand_sweep_ctrl
    import nand_sweep_pkg::*;
#(
    parameter int N_IN     = 3,
    parameter int HOLD_CYC = HOLD_CYC_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    output logic [N_IN-1:0] vec_out,
    input  logic            y_s,
    input  logic            y_d,
    input  logic            y_b,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic [2:0]      fail_mask,
    output logic [N_IN-1:0] first_err_vec,
    output logic            first_err_vld
);

    localparam int EW = N_IN + 1;
    localparam int TW = $clog2(HOLD_CYC) + 1;
    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYC - 1);

    state_t          r_state;
    logic [N_IN-1:0] r_vec;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;
    logic [EW-1:0]   r_err_cnt;
    logic [2:0]      r_fail_mask;
    logic [N_IN-1:0] r_first_vec;
    logic            r_first_vld;

    logic            w_golden;
    logic [2:0]      w_mism;
    logic            w_any;
    logic [EW-1:0]   w_err_next;
    logic            w_last;
    logic            w_begin;
    logic            w_load;
    logic            w_zero;

    // Compare logic is only consumed in CHECK, when vec_out has settled.
    assign w_golden   = golden_nand(32'(r_vec), N_IN);
    assign w_mism     = {y_s, y_d, y_b} ^ {3{w_golden}};
    assign w_any      = |w_mism;
    assign w_err_next = r_err_cnt + EW'(w_any);
    assign w_last     = (r_vec == '1);
    assign w_begin    = !abort && start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_load     = w_begin || (!abort && (r_state == ST_CHECK) && !w_last);

    sweep_hold_timer #(
        .W (TW)
    ) u_hold_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (HOLD_LOAD),
        .i_en       (r_state == ST_APPLY),
        .o_zero     (w_zero)
    );

    // Sweep FSM with vector counter and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_vec       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_cnt   <= '0;
            r_fail_mask <= '0;
            r_first_vec <= '0;
            r_first_vld <= 1'b0;
        end else if (abort) begin
            // Results survive an abort; only the sequencing is unwound.
            r_state <= ST_IDLE;
            r_vec   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state     <= ST_APPLY;
                        r_vec       <= '0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_err_cnt   <= '0;
                        r_fail_mask <= '0;
                        r_first_vec <= '0;
                        r_first_vld <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    if (w_zero) begin
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_any) begin
                        r_err_cnt   <= w_err_next;
                        r_fail_mask <= r_fail_mask | w_mism;
                        if (!r_first_vld) begin
                            r_first_vec <= r_vec;
                            r_first_vld <= 1'b1;
                        end
                    end
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == '0);
                    end else begin
                        r_state <= ST_APPLY;
                        r_vec   <= r_vec + N_IN'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign vec_out       = r_vec;
    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign err_cnt       = r_err_cnt;
    assign fail_mask     = r_fail_mask;
    assign first_err_vec = r_first_vec;
    assign first_err_vld = r_first_vld;

endmodule

// File: tb/tb_nand_sweep_ctrl.sv
// Directed bench for nand_sweep_ctrl: behavioural gate models with
// injectable faults, a per-sweep result scoreboard and timing checks.
module tb_nand_sweep_ctrl;

    localparam int N_IN   = 3;
    localparam int HOLD   = 4;
    localparam int PER    = HOLD + 1;
    localparam int NVEC   = 1 << N_IN;
    localparam int DONE_C = NVEC * PER + 1;

    typedef struct {
        logic [N_IN:0]   err;
        logic [2:0]      mask;
        logic [N_IN-1:0] fvec;
        logic            fvld;
        logic            pass;
    } res_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [N_IN-1:0] vec_out;
    logic            y_s, y_d, y_b;
    logic            busy, done, pass, first_err_vld;
    logic [N_IN:0]   err_cnt;
    logic [2:0]      fail_mask;
    logic [N_IN-1:0] first_err_vec;

    bit s_inv = 1'b0, d_one = 1'b0, b_zero = 1'b0;

    int   n_vec  = 0;
    int   n_miss = 0;
    res_t sb_q[$];

    always #5 clk = ~clk;

    // Three gate implementations, with optional planted faults.
    always_comb begin
        y_s = s_inv  ? (&vec_out) : ~(&vec_out);
        y_d = d_one  ? 1'b1       : ~(&vec_out);
        y_b = b_zero ? 1'b0       : ~(&vec_out);
    end

    nand_sweep_ctrl #(.N_IN(N_IN), .HOLD_CYC(HOLD)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .vec_out       (vec_out),
        .y_s           (y_s),
        .y_d           (y_d),
        .y_b           (y_b),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_cnt       (err_cnt),
        .fail_mask     (fail_mask),
        .first_err_vec (first_err_vec),
        .first_err_vld (first_err_vld)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected results after the first nv vectors under the current faults.
    function automatic res_t model(input int nv);
        res_t r;
        logic g, ys, yd, yb;
        logic [2:0] m;
        r = '{err: '0, mask: '0, fvec: '0, fvld: 1'b0, pass: 1'b0};
        for (int v = 0; v < nv; v++) begin
            g  = (v != NVEC - 1);
            ys = s_inv  ? ~g   : g;
            yd = d_one  ? 1'b1 : g;
            yb = b_zero ? 1'b0 : g;
            m  = {ys != g, yd != g, yb != g};
            if (m != 3'b000) begin
                r.err  = r.err + 1'b1;
                r.mask = r.mask | m;
                if (!r.fvld) begin
                    r.fvec = N_IN'(v);
                    r.fvld = 1'b1;
                end
            end
        end
        r.pass = (r.err == '0);
        return r;
    endfunction

    task automatic run_sweep(input string name, input bit poke_busy);
        int   c;
        res_t e;
        sb_q.push_back(model(NVEC));
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 1;
        while (1) begin
            check({name, "_vec"},  32'(vec_out), (c <= NVEC * PER) ? 32'((c - 1) / PER) : 32'(NVEC - 1));
            check({name, "_busy"}, 32'(busy), 32'(c < DONE_C));
            if (c == 1) begin
                check({name, "_clr_err"},  32'(err_cnt), 0);
                check({name, "_clr_mask"}, 32'(fail_mask), 0);
                check({name, "_clr_vld"},  32'(first_err_vld), 0);
            end
            if (done === 1'b1 || c >= 200) break;
            start = poke_busy && (c == 10 || c == 23);
            tick();
            c++;
        end
        start = 1'b0;
        check({name, "_done_cycle"}, c, DONE_C);
        check({name, "_done"}, 32'(done), 1);
        e = sb_q.pop_front();
        check({name, "_err_cnt"},   32'(err_cnt), 32'(e.err));
        check({name, "_fail_mask"}, 32'(fail_mask), 32'(e.mask));
        check({name, "_first_vld"}, 32'(first_err_vld), 32'(e.fvld));
        if (e.fvld) check({name, "_first_vec"}, 32'(first_err_vec), 32'(e.fvec));
        check({name, "_pass"}, 32'(pass), 32'(e.pass));
    endtask

    initial begin
        res_t e;

        // Reset values while rst_n is held low.
        #2;
        check("rst_vec",  32'(vec_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_pass", 32'(pass), 0);
        check("rst_err",  32'(err_cnt), 0);
        check("rst_mask", 32'(fail_mask), 0);
        check("rst_fvec", 32'(first_err_vec), 0);
        check("rst_fvld", 32'(first_err_vld), 0);
        #10 rst_n = 1'b1;
        tick();

        // Healthy sweep.
        run_sweep("healthy", 1'b0);

        // y_d stuck at 1: only vector 7 fails.
        d_one = 1'b1;
        run_sweep("stuck_d", 1'b0);
        d_one = 1'b0;

        // y_s inverted and y_b stuck at 0: every vector fails.
        s_inv  = 1'b1;
        b_zero = 1'b1;
        run_sweep("multi", 1'b0);
        s_inv  = 1'b0;
        b_zero = 1'b0;

        // Restart from DONE with start pulses while busy.
        d_one = 1'b1;
        run_sweep("pre_restart", 1'b0);
        d_one = 1'b0;
        run_sweep("restart", 1'b1);

        // Start and abort together in DONE: abort wins, no restart.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("sa_done", 32'(done), 0);
        check("sa_busy", 32'(busy), 0);
        check("sa_vec",  32'(vec_out), 0);
        check("sa_pass", 32'(pass), 0);
        repeat (3) tick();
        check("sa_stay_idle", 32'(busy), 0);

        // Abort during vector 2 APPLY keeps the accumulated results.
        s_inv  = 1'b1;
        b_zero = 1'b1;
        e = model(2);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (11) tick();
        check("ab_pre_vec",  32'(vec_out), 2);
        check("ab_pre_busy", 32'(busy), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_busy", 32'(busy), 0);
        check("ab_done", 32'(done), 0);
        check("ab_vec",  32'(vec_out), 0);
        check("ab_err",  32'(err_cnt), 32'(e.err));
        check("ab_mask", 32'(fail_mask), 32'(e.mask));
        check("ab_fvld", 32'(first_err_vld), 32'(e.fvld));
        check("ab_fvec", 32'(first_err_vec), 32'(e.fvec));
        repeat (3) tick();
        check("ab_stay_idle", 32'(busy), 0);

        // Asynchronous reset in the middle of vector 1's CHECK cycle.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        check("ar_pre_vec", 32'(vec_out), 1);
        check("ar_pre_err", 32'(err_cnt), 1);
        #3 rst_n = 1'b0;
        #1;
        check("ar_vec",  32'(vec_out), 0);
        check("ar_busy", 32'(busy), 0);
        check("ar_done", 32'(done), 0);
        check("ar_pass", 32'(pass), 0);
        check("ar_err",  32'(err_cnt), 0);
        check("ar_mask", 32'(fail_mask), 0);
        check("ar_fvec", 32'(first_err_vec), 0);
        check("ar_fvld", 32'(first_err_vld), 0);
        #1 rst_n = 1'b1;
        s_inv  = 1'b0;
        b_zero = 1'b0;
        tick();
        run_sweep("post_reset", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
